// File: rtl/shift_pipe_if.sv
// Valid/ready handshake bundle carrying one data word per transfer.
interface shift_pipe_if #(
    parameter int unsigned W = 8
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    // Producer side drives valid/data, consumer side drives ready.
    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/shift_pipe.sv
// Pipelined multi-mode barrel shifter (LSL/LSR/ASR/ROL) joining a data word
// with a shift-config word; elastic stages with per-stage valid bits.
module shift_pipe #(
    parameter int unsigned DIN_W   = 16,
    parameter int unsigned DOUT_W  = 16,
    parameter int unsigned SHAMT_W = 4,
    parameter int unsigned STAGES  = 2,
    parameter int unsigned SIGNED  = 0
) (
    input  logic          clk,
    input  logic          rst,
    shift_pipe_if.slave   din,
    shift_pipe_if.slave   cfg,
    shift_pipe_if.master  dout
);

    localparam int unsigned IW = (DIN_W > DOUT_W) ? DIN_W : DOUT_W;

    typedef enum logic [1:0] {
        MODE_LSL = 2'd0,
        MODE_LSR = 2'd1,
        MODE_ASR = 2'd2,
        MODE_ROL = 2'd3
    } mode_e;

    logic [STAGES-1:0]  v_q;
    logic [IW-1:0]      w_q    [STAGES];
    mode_e              mode_q [STAGES];
    logic [SHAMT_W-1:0] sh_q   [STAGES];

    logic [STAGES:0]    adv;
    logic [STAGES-1:0]  vin;
    logic               acc;
    logic [IW-1:0]      src_w  [STAGES];
    mode_e              src_m  [STAGES];
    logic [SHAMT_W-1:0] src_s  [STAGES];
    logic [IW-1:0]      w_d    [STAGES];

    // Stage that applies shift-amount bit b.
    function automatic int unsigned stage_of(input int unsigned b);
        return (b * STAGES) / SHAMT_W;
    endfunction

    // Rotate distance of shamt bit b inside DIN_W: 2^b mod DIN_W.
    function automatic int unsigned rol_amt(input int unsigned b);
        int unsigned m;
        m = 1 % DIN_W;
        for (int unsigned i = 0; i < b; i++) begin
            m = (2 * m) % DIN_W;
        end
        return m;
    endfunction

    // Extend a DIN_W operand to the internal width.
    function automatic logic [IW-1:0] ext_din(input logic [DIN_W-1:0] x);
        if (SIGNED != 0) begin
            return IW'($signed(x));
        end
        return IW'(x);
    endfunction

    // Apply the shamt bits owned by stage k; oversized amounts saturate to IW.
    function automatic logic [IW-1:0] stage_shift(input logic [IW-1:0]      w,
                                                  input mode_e              m,
                                                  input logic [SHAMT_W-1:0] s,
                                                  input int unsigned        k);
        logic [IW-1:0]    r;
        logic [DIN_W-1:0] rl;
        int unsigned      n;
        r = w;
        for (int unsigned b = 0; b < SHAMT_W; b++) begin
            if (stage_of(b) == k && s[b]) begin
                n = (b >= 31) ? IW : (32'd1 << b);
                if (n > IW) begin
                    n = IW;
                end
                case (m)
                    MODE_LSL: r = (n >= IW) ? '0 : (r << n);
                    MODE_LSR: r = (n >= IW) ? '0 : (r >> n);
                    MODE_ASR: r = (n >= IW) ? {IW{r[IW-1]}} : IW'($signed(r) >>> n);
                    MODE_ROL: begin
                        rl = r[DIN_W-1:0];
                        n  = rol_amt(b);
                        if (n != 0) begin
                            rl = (rl << n) | (rl >> (DIN_W - n));
                        end
                        r[DIN_W-1:0] = rl;
                    end
                    default: ;
                endcase
            end
        end
        return r;
    endfunction

    // Advance chain, joint accept, and next-stage data for every stage.
    always_comb begin
        adv         = '0;
        vin         = '0;
        adv[STAGES] = dout.ready;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            adv[k] = ~v_q[k] | adv[k+1];
        end
        acc = din.valid & cfg.valid & adv[0] & rst;

        for (int unsigned k = 0; k < STAGES; k++) begin
            src_w[k] = '0;
            src_m[k] = MODE_LSL;
            src_s[k] = '0;
            w_d[k]   = '0;
            if (k == 0) begin
                src_w[k] = ext_din(din.data);
                src_m[k] = mode_e'(cfg.data[SHAMT_W+1:SHAMT_W]);
                src_s[k] = cfg.data[SHAMT_W-1:0];
                vin[k]   = acc;
            end else begin
                src_w[k] = w_q[k-1];
                src_m[k] = mode_q[k-1];
                src_s[k] = sh_q[k-1];
                vin[k]   = v_q[k-1];
            end
            w_d[k] = stage_shift(src_w[k], src_m[k], src_s[k], k);
            // Rotation lives in DIN_W; widen or truncate only once it is complete.
            if (k == STAGES - 1 && src_m[k] == MODE_ROL) begin
                w_d[k] = ext_din(w_d[k][DIN_W-1:0]);
            end
        end
    end

    // Stage registers: valids move with adv, data loads only on a valid advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                w_q[k]    <= '0;
                mode_q[k] <= MODE_LSL;
                sh_q[k]   <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    v_q[k] <= vin[k];
                end
                if (adv[k] && vin[k]) begin
                    w_q[k]    <= w_d[k];
                    mode_q[k] <= src_m[k];
                    sh_q[k]   <= src_s[k];
                end
            end
        end
    end

    assign din.ready  = acc;
    assign cfg.ready  = acc;
    assign dout.valid = v_q[STAGES-1];
    assign dout.data  = w_q[STAGES-1][DOUT_W-1:0];

endmodule
